// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits (LSB- or MSB-first), optional
// even parity (SERIAL_FRAME_PARITY_EN), stop bit; each line bit held CLKS_PER_BIT cycles.
module serial_frame_tx #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              trigger,
    input  logic [DATA_W-1:0] data_in,
    input  logic              msb_first,
    output logic              data_out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IdxW = $clog2(DATA_W);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_W - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef SERIAL_FRAME_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [IdxW-1:0]   bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              msb_q, msb_d;
    logic              data_out_q, data_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef SERIAL_FRAME_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic              last_cycle;
    logic [DATA_W-1:0] shifted;

    assign last_cycle = (cnt_q == CntLast);
    // The transmitted bit always sits at the end the register shifts out of.
    assign shifted    = msb_q ? (shreg_q << 1) : (shreg_q >> 1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        msb_d      = msb_q;
        data_out_d = data_out_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
        parity_d   = parity_q;
`endif

        unique case (state_q)
            StIdle: begin
                data_out_d = 1'b1;
                busy_d     = 1'b0;
                if (trigger && !busy_q) begin
                    state_d    = StStart;
                    cnt_d      = '0;
                    bit_idx_d  = '0;
                    shreg_d    = data_in;
                    msb_d      = msb_first;
                    data_out_d = 1'b0;
                    busy_d     = 1'b1;
`ifdef SERIAL_FRAME_PARITY_EN
                    parity_d   = ^data_in;
`endif
                end
            end
            StStart: begin
                if (last_cycle) begin
                    cnt_d      = '0;
                    state_d    = StData;
                    data_out_d = msb_q ? shreg_q[DATA_W-1] : shreg_q[0];
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (last_cycle) begin
                    cnt_d = '0;
                    if (bit_idx_q == IdxLast) begin
                        bit_idx_d  = '0;
`ifdef SERIAL_FRAME_PARITY_EN
                        state_d    = StParity;
                        data_out_d = parity_q;
`else
                        state_d    = StStop;
                        data_out_d = 1'b1;
`endif
                    end else begin
                        bit_idx_d  = bit_idx_q + IdxW'(1);
                        shreg_d    = shifted;
                        data_out_d = msb_q ? shifted[DATA_W-1] : shifted[0];
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
`ifdef SERIAL_FRAME_PARITY_EN
            StParity: begin
                if (last_cycle) begin
                    cnt_d      = '0;
                    state_d    = StStop;
                    data_out_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
`endif
            StStop: begin
                if (last_cycle) begin
                    cnt_d      = '0;
                    state_d    = StIdle;
                    data_out_d = 1'b1;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d    = StIdle;
                data_out_d = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            msb_q      <= 1'b0;
            data_out_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            msb_q      <= msb_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef SERIAL_FRAME_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign data_out = data_out_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
